// File: rtl/cajero_automatico_param.sv
// -----------------------------------------------------------------------------
// cajero_automatico_param
// ATM session controller: card detect, PIN entry and verification with an
// attempt counter and lockout, idle timeout, and a single transaction per
// session (deposit / withdraw / balance query). Withdrawals are bounded by the
// account balance and by a daily cumulative cap.
//
// Ports
//   clk                   clock
//   reset                 synchronous active-low reset
//   tarjeta_recibida      card inserted (seen only while waiting for a card)
//   digito_stb / digito   PIN digit strobe and value (seen only during PIN entry)
//   pin_correcto          stored PIN, first digit in the most significant nibble
//   tipo_trans            00 deposit, 01 withdraw, 10 balance query, 11 none
//   trans_stb / monto     transaction request strobe and amount
//   balance_inicial       account balance presented to the controller
//   dia_nuevo             clears the daily withdrawal accumulator
//   pin_incorrecto        one-cycle pulse per rejected PIN
//   advertencia           level, one attempt left before lockout
//   bloqueo               level, card locked until reset
//   balance_stb           balance_actualizado carries a fresh value
//   entregar_dinero       dispense pulse for an accepted withdrawal
//   fondos_insuficientes  withdrawal rejected: amount above balance
//   limite_excedido       withdrawal rejected: daily cap would be exceeded
//   timeout_err           one-cycle pulse when an idle session is aborted
//   balance_actualizado   resulting balance, held between transactions
//
// state          | meaning
// ---------------+-------------------------------------------------------------
// ESPERA_TARJETA | idle, waiting for a card
// INGRESO_PIN    | collecting PIN digits, idle timer running
// VERIFICA       | single cycle, compares entered PIN with stored PIN
// ESPERA_TRANS   | PIN accepted, waiting for a transaction request
// PROCESA        | single cycle, evaluates the captured transaction
// BLOQUEADO      | too many wrong PINs, only reset leaves this state
// -----------------------------------------------------------------------------
module cajero_automatico_param #(
   parameter int               PIN_DIGITS     = 4,
   parameter int               MAX_INTENTOS   = 3,
   parameter int               BAL_W          = 64,
   parameter int               MONTO_W        = 32,
   parameter int               TIMEOUT_CICLOS = 1000,
   parameter logic [BAL_W-1:0] LIMITE_DIARIO  = BAL_W'(500000)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    tarjeta_recibida,
   input  logic                    digito_stb,
   input  logic [3:0]              digito,
   input  logic [4*PIN_DIGITS-1:0] pin_correcto,
   input  logic [1:0]              tipo_trans,
   input  logic                    trans_stb,
   input  logic [MONTO_W-1:0]      monto,
   input  logic [BAL_W-1:0]        balance_inicial,
   input  logic                    dia_nuevo,
   output logic                    pin_incorrecto,
   output logic                    advertencia,
   output logic                    bloqueo,
   output logic                    balance_stb,
   output logic                    entregar_dinero,
   output logic                    fondos_insuficientes,
   output logic                    limite_excedido,
   output logic                    timeout_err,
   output logic [BAL_W-1:0]        balance_actualizado
);

   localparam int PIN_W = 4 * PIN_DIGITS;
   localparam int DIG_W = $clog2(PIN_DIGITS + 1);
   localparam int ATT_W = $clog2(MAX_INTENTOS + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CICLOS + 1);

   localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(PIN_DIGITS - 1);
   localparam logic [ATT_W-1:0] ATT_MAX  = ATT_W'(MAX_INTENTOS);
   localparam logic [ATT_W-1:0] ATT_WARN = ATT_W'(MAX_INTENTOS - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CICLOS - 1);

   typedef enum logic [2:0] {
      ESPERA_TARJETA,
      INGRESO_PIN,
      VERIFICA,
      ESPERA_TRANS,
      PROCESA,
      BLOQUEADO
   } state_t;

   state_t             state_q, state_d;
   logic [DIG_W-1:0]   dig_cnt_q, dig_cnt_d;
   logic [PIN_W-1:0]   pin_q, pin_d;
   logic [ATT_W-1:0]   att_q, att_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic [1:0]         tipo_q, tipo_d;
   logic [MONTO_W-1:0] monto_q, monto_d;
   logic [BAL_W-1:0]   acum_q, acum_d;
   logic [BAL_W-1:0]   balance_q, balance_d;

   logic pin_incorrecto_q, pin_incorrecto_d;
   logic advertencia_q, advertencia_d;
   logic bloqueo_q, bloqueo_d;
   logic balance_stb_q, balance_stb_d;
   logic entregar_q, entregar_d;
   logic fondos_q, fondos_d;
   logic limite_q, limite_d;
   logic timeout_q, timeout_d;

   logic               pin_match;
   logic               tmo_hit;
   logic [ATT_W-1:0]   att_inc;
   logic [BAL_W-1:0]   monto_ext;
   logic [BAL_W:0]     dep_sum;
   logic [BAL_W:0]     acum_sum;
   logic [BAL_W-1:0]   acum_base;

   assign pin_match = (pin_q == pin_correcto);
   assign tmo_hit   = (tmo_q == TMO_LAST);
   assign att_inc   = att_q + 1'b1;
   assign monto_ext = BAL_W'(monto_q);
   // One extra bit so saturation and the cap comparison see the carry.
   assign dep_sum   = {1'b0, balance_inicial} + {1'b0, monto_ext};
   assign acum_sum  = {1'b0, acum_q} + {1'b0, monto_ext};
   // A new day coincident with a commit restarts the accumulator from zero.
   assign acum_base = dia_nuevo ? '0 : acum_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q          <= ESPERA_TARJETA;
         dig_cnt_q        <= '0;
         pin_q            <= '0;
         att_q            <= '0;
         tmo_q            <= '0;
         tipo_q           <= '0;
         monto_q          <= '0;
         acum_q           <= '0;
         balance_q        <= '0;
         pin_incorrecto_q <= 1'b0;
         advertencia_q    <= 1'b0;
         bloqueo_q        <= 1'b0;
         balance_stb_q    <= 1'b0;
         entregar_q       <= 1'b0;
         fondos_q         <= 1'b0;
         limite_q         <= 1'b0;
         timeout_q        <= 1'b0;
      end else begin
         state_q          <= state_d;
         dig_cnt_q        <= dig_cnt_d;
         pin_q            <= pin_d;
         att_q            <= att_d;
         tmo_q            <= tmo_d;
         tipo_q           <= tipo_d;
         monto_q          <= monto_d;
         acum_q           <= acum_d;
         balance_q        <= balance_d;
         pin_incorrecto_q <= pin_incorrecto_d;
         advertencia_q    <= advertencia_d;
         bloqueo_q        <= bloqueo_d;
         balance_stb_q    <= balance_stb_d;
         entregar_q       <= entregar_d;
         fondos_q         <= fondos_d;
         limite_q         <= limite_d;
         timeout_q        <= timeout_d;
      end
   end

   // Next state, session counters and captured request.
   always_comb begin
      state_d   = state_q;
      dig_cnt_d = dig_cnt_q;
      pin_d     = pin_q;
      att_d     = att_q;
      tmo_d     = tmo_q;
      tipo_d    = tipo_q;
      monto_d   = monto_q;
      case (state_q)
         ESPERA_TARJETA: begin
            if (tarjeta_recibida) begin
               state_d   = INGRESO_PIN;
               dig_cnt_d = '0;
               tmo_d     = '0;
            end
         end
         INGRESO_PIN: begin
            if (digito_stb) begin
               pin_d = PIN_W'({pin_q, digito});
               tmo_d = '0;
               if (dig_cnt_q == DIG_LAST) begin
                  state_d   = VERIFICA;
                  dig_cnt_d = '0;
               end else begin
                  dig_cnt_d = dig_cnt_q + 1'b1;
               end
            end else if (tmo_hit) begin
               state_d = ESPERA_TARJETA;
               tmo_d   = '0;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         VERIFICA: begin
            dig_cnt_d = '0;
            tmo_d     = '0;
            if (pin_match) begin
               state_d = ESPERA_TRANS;
               att_d   = '0;
            end else begin
               att_d   = att_inc;
               state_d = (att_inc == ATT_MAX) ? BLOQUEADO : INGRESO_PIN;
            end
         end
         ESPERA_TRANS: begin
            if (trans_stb) begin
               state_d = PROCESA;
               tipo_d  = tipo_trans;
               monto_d = monto;
               tmo_d   = '0;
            end else if (tmo_hit) begin
               state_d = ESPERA_TARJETA;
               tmo_d   = '0;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         PROCESA:   state_d = ESPERA_TARJETA;
         BLOQUEADO: state_d = BLOQUEADO;
         default:   state_d = ESPERA_TARJETA;
      endcase
   end

   // Registered outputs and transaction datapath.
   always_comb begin
      pin_incorrecto_d = 1'b0;
      balance_stb_d    = 1'b0;
      entregar_d       = 1'b0;
      fondos_d         = 1'b0;
      limite_d         = 1'b0;
      timeout_d        = 1'b0;
      advertencia_d    = advertencia_q;
      bloqueo_d        = bloqueo_q;
      balance_d        = balance_q;
      acum_d           = acum_base;
      case (state_q)
         INGRESO_PIN:  timeout_d = !digito_stb && tmo_hit;
         ESPERA_TRANS: timeout_d = !trans_stb && tmo_hit;
         VERIFICA: begin
            if (pin_match) begin
               advertencia_d = 1'b0;
            end else begin
               pin_incorrecto_d = 1'b1;
               advertencia_d    = (att_inc == ATT_WARN);
               if (att_inc == ATT_MAX) bloqueo_d = 1'b1;
            end
         end
         PROCESA: begin
            case (tipo_q)
               2'b00: begin
                  balance_d     = dep_sum[BAL_W] ? '1 : dep_sum[BAL_W-1:0];
                  balance_stb_d = 1'b1;
               end
               2'b01: begin
                  if (monto_ext > balance_inicial) begin
                     fondos_d = 1'b1;
                  end else if (acum_sum > {1'b0, LIMITE_DIARIO}) begin
                     limite_d = 1'b1;
                  end else begin
                     balance_d     = balance_inicial - monto_ext;
                     balance_stb_d = 1'b1;
                     entregar_d    = 1'b1;
                     acum_d        = acum_base + monto_ext;
                  end
               end
               2'b10: begin
                  balance_d     = balance_inicial;
                  balance_stb_d = 1'b1;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign pin_incorrecto       = pin_incorrecto_q;
   assign advertencia          = advertencia_q;
   assign bloqueo              = bloqueo_q;
   assign balance_stb          = balance_stb_q;
   assign entregar_dinero      = entregar_q;
   assign fondos_insuficientes = fondos_q;
   assign limite_excedido      = limite_q;
   assign timeout_err          = timeout_q;
   assign balance_actualizado  = balance_q;

endmodule
